load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on rising edge.
REQ-002 SHALL have rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have req, input, 1, CPU access request; sampled only when ready=1.
REQ-004 SHALL have we, input, 1, 1=store, 0=load.
REQ-005 SHALL have size, input, 2, 00=byte, 01=halfword, 10=word, 11=reserved.
REQ-006 SHALL have sign_ext, input, 1, loads: 1=sign-extend, 0=zero-extend.
REQ-007 SHALL have addr, input, 32, byte address.
REQ-008 SHALL have wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have ready, output, 1, high only in IDLE.
REQ-010 SHALL have done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have err, output, 1, high with done when the access was rejected.
REQ-012 SHALL have rdata, output, 32, load result, right-aligned and extended.
REQ-013 SHALL have ram_wren, output, 1, RAM write enable.
REQ-014 SHALL have ram_address, output, 30, RAM word index.
REQ-015 SHALL have ram_data, output, 32, RAM write word.
REQ-016 SHALL have ram_q, input, 32, RAM read word, valid one cycle after ram_address is presented.

Function
REQ-017 SHALL use the states IDLE, READ, WAIT, WRITE, RESP.
REQ-018 SHALL, in IDLE with req=1, latch addr, size, we, wdata and sign_ext.
REQ-019 SHALL treat size=11, halfword with addr[0]=1, and word with addr[1:0]!=0 as misaligned: go to RESP with err=1 and no RAM write.
REQ-020 SHALL route an aligned word store IDLE->WRITE->RESP; done is asserted 2 cycles after the accept edge.
REQ-021 SHALL route a load IDLE->READ->WAIT->RESP; done is asserted 3 cycles after the accept edge.
REQ-022 SHALL route a byte or halfword store IDLE->READ->WAIT->WRITE->RESP (read-modify-write); done is asserted 4 cycles after the accept edge.
REQ-023 SHALL drive ram_address=latched addr[31:2] in READ, WAIT and WRITE, and 0 in IDLE and RESP.
REQ-024 SHALL assert ram_wren only in WRITE; ram_data SHALL be the merged word in WRITE and 0 otherwise.
REQ-025 SHALL use little-endian lane selection: byte lane = addr[1:0]; halfword lane = addr[1] (bits 15:0 or 31:16).
REQ-026 SHALL, in WAIT, capture ram_q: for a load, register the extracted lane into rdata; for a sub-word store, register ram_q with only the target lane replaced by wdata low bits.
REQ-027 SHALL hold rdata until the next completed load; stores and errors SHALL leave rdata unchanged.
REQ-028 SHALL assert done (and err if rejected) only in RESP, for exactly one cycle, then return to IDLE.
REQ-029 SHALL ignore req while ready=0, with no queuing.
REQ-030 SHALL allow a new request to be accepted in the first IDLE cycle after RESP.

Reset
REQ-031 SHALL, on rst_n low, immediately force: state=IDLE, ready=1, done=0, err=0, rdata=0, ram_wren=0, ram_address=0, ram_data=0, and clear all latched request registers.
REQ-032 SHALL abandon any access in progress on reset assertion, with no write issued afterward; a pending RMW write is dropped.

Structure
REQ-033 SHALL place the size encodings, the state enumeration and the RAM word-index width (30) in the shared package kanade_mem_pkg.
REQ-034 SHALL implement lane extraction, extension and merge in one combinational sub-module, lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-035 Word store addr=0x10, wdata=0xDEADBEEF -> ram_wren=1 for one cycle with ram_address=4 and ram_data=0xDEADBEEF; done 2 cycles after accept; err=0.
REQ-036 RAM word 4=0x8899AABB; byte load addr=0x13, sign_ext=1 -> rdata=0xFFFFFF88 with done 3 cycles after accept; the same load with sign_ext=0 -> rdata=0x00000088.
REQ-037 RAM word 4=0x11223344; halfword store addr=0x12, wdata=0x0000CAFE -> one write of 0xCAFE3344 to ram_address=4; done 4 cycles after accept.
REQ-038 Halfword load addr=0x11, or size=11 -> done=err=1 one cycle after accept; ram_wren stays 0; rdata unchanged.
REQ-039 rst_n pulsed low during the WAIT state of a byte store -> outputs return to reset values asynchronously; no ram_wren pulse; the RAM word is unchanged; the next request completes normally.
REQ-040 req held high through a load -> exactly one access completes; a second is accepted in the first IDLE cycle after RESP.

Source files
------------

// File: rtl/kanade_mem_pkg.sv
// rtl/kanade_mem_pkg.sv - shared encodings and helpers for the load/store unit
package kanade_mem_pkg;

  localparam int unsigned RAM_AW = 30;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    RESP
  } lsu_state_e;

  // Reserved size is treated as misaligned so it takes the reject path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      SIZE_WORD: return lane != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request and RAM port bundle for the load/store unit
interface load_store_unit_if;
  import kanade_mem_pkg::*;

  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              ram_wren;
  logic [RAM_AW-1:0] ram_address;
  logic [31:0]       ram_data;
  logic [31:0]       ram_q;

  modport master (
    output req, we, size, sign_ext, addr, wdata, ram_q,
    input  ready, done, err, rdata, ram_wren, ram_address, ram_data
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, ram_q,
    output ready, done, err, rdata, ram_wren, ram_address, ram_data
  );

endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - little-endian lane extract/extend and sub-word merge
module lsu_align
  import kanade_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        sign_ext_i,
  input  logic [31:0] ram_q_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = ram_q_i[{lane_i, 3'b000} +: 8];
    half_sel     = lane_i[1] ? ram_q_i[31:16] : ram_q_i[15:0];
    load_data_o  = ram_q_i;
    merge_data_o = ram_q_i;
    case (size_i)
      SIZE_BYTE: begin
        load_data_o = {{24{sign_ext_i & byte_sel[7]}}, byte_sel};
        merge_data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_HALF: begin
        load_data_o = {{16{sign_ext_i & half_sel[15]}}, half_sel};
        if (lane_i[1]) merge_data_o[31:16] = wdata_i[15:0];
        else           merge_data_o[15:0]  = wdata_i[15:0];
      end
      default: begin
        load_data_o  = ram_q_i;
        merge_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store FSM with read-modify-write for sub-word stores
module load_store_unit
  import kanade_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wword_q, wword_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        sign_ext_q, sign_ext_d;
  logic        err_q, err_d;

  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        misaligned;

  lsu_align u_align (
    .size_i       (size_q),
    .lane_i       (addr_q[1:0]),
    .sign_ext_i   (sign_ext_q),
    .ram_q_i      (bus.ram_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  assign misaligned = is_misaligned(bus.size, bus.addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wword_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wword_q    <= wword_d;
      rdata_q    <= rdata_d;
      size_q     <= size_d;
      we_q       <= we_d;
      sign_ext_q <= sign_ext_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wword_d         = wword_q;
    rdata_d         = rdata_q;
    size_d          = size_q;
    we_d            = we_q;
    sign_ext_d      = sign_ext_q;
    err_d           = err_q;
    bus.ready       = 1'b0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;
    bus.ram_wren    = 1'b0;
    bus.ram_address = '0;
    bus.ram_data    = '0;

    case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.req) begin
          addr_d     = bus.addr;
          wdata_d    = bus.wdata;
          wword_d    = bus.wdata;
          size_d     = bus.size;
          we_d       = bus.we;
          sign_ext_d = bus.sign_ext;
          err_d      = misaligned;
          if (misaligned)                             state_d = RESP;
          else if (bus.we && bus.size == SIZE_WORD)   state_d = WRITE;
          else                                        state_d = READ;
        end
      end
      READ: begin
        bus.ram_address = addr_q[31:2];
        state_d         = WAIT;
      end
      WAIT: begin
        // ram_q now holds the word addressed in READ.
        bus.ram_address = addr_q[31:2];
        if (we_q) begin
          wword_d = merge_data;
          state_d = WRITE;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WRITE: begin
        bus.ram_address = addr_q[31:2];
        bus.ram_wren    = 1'b1;
        bus.ram_data    = wword_q;
        state_d         = RESP;
      end
      RESP: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import kanade_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:63];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;
  int          wr_cnt = 0;
  logic [29:0] wr_addr;
  logic [31:0] wr_data;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) begin
    bus.ram_q <= mem[bus.ram_address[5:0]];
    if (bus.ram_wren) begin
      mem[bus.ram_address[5:0]] <= bus.ram_data;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.ram_address;
      wr_data <= bus.ram_data;
    end
    if (poke_en) mem[poke_idx] <= poke_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    @(negedge clk);
    poke_en  = 1'b0;
  endtask

  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, input int exp_wr);
    int   lat;
    int   wr0;
    logic e;
    lat = 0;
    e   = 1'b0;
    @(negedge clk);
    check({tag, ".ready"}, 32'(bus.ready), 32'd1);
    wr0          = wr_cnt;
    bus.req      = 1'b1;
    bus.we       = w;
    bus.size     = sz;
    bus.sign_ext = sx;
    bus.addr     = a;
    bus.wdata    = wd;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (bus.done) begin
        lat = n;
        e   = bus.err;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, 32'(e), 32'(exp_err));
    check({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    @(posedge clk);
    #1;
    check({tag, ".done_drop"}, 32'(bus.done), 32'd0);
  endtask

  logic [7:0] done_v;
  logic [7:0] rdy_v;
  int         wr_snap;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.size     = 2'b00;
    bus.sign_ext = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    poke_en      = 1'b0;
    poke_idx     = '0;
    poke_val     = '0;
    #1;
    check("rst.ready", 32'(bus.ready), 32'd1);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.err", 32'(bus.err), 32'd0);
    check("rst.rdata", bus.rdata, 32'h0);
    check("rst.wren", 32'(bus.ram_wren), 32'd0);
    check("rst.address", 32'(bus.ram_address), 32'd0);
    check("rst.data", bus.ram_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    access("sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 1);
    check("sw.addr", 32'(wr_addr), 32'd4);
    check("sw.data", wr_data, 32'hDEADBEEF);
    check("sw.mem", mem[4], 32'hDEADBEEF);

    poke(6'd4, 32'h8899AABB);
    access("lb_sx", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 3, 1'b0, 0);
    check("lb_sx.rdata", bus.rdata, 32'hFFFFFF88);
    access("lb_zx", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 3, 1'b0, 0);
    check("lb_zx.rdata", bus.rdata, 32'h00000088);
    access("lb0_sx", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 3, 1'b0, 0);
    check("lb0_sx.rdata", bus.rdata, 32'hFFFFFFBB);
    access("lh_sx", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 3, 1'b0, 0);
    check("lh_sx.rdata", bus.rdata, 32'hFFFF8899);
    access("lh0_zx", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 3, 1'b0, 0);
    check("lh0_zx.rdata", bus.rdata, 32'h0000AABB);
    access("lw", 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 3, 1'b0, 0);
    check("lw.rdata", bus.rdata, 32'h8899AABB);

    poke(6'd4, 32'h11223344);
    access("sh", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE, 4, 1'b0, 1);
    check("sh.addr", 32'(wr_addr), 32'd4);
    check("sh.data", wr_data, 32'hCAFE3344);
    access("sb", 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456A5, 4, 1'b0, 1);
    check("sb.data", wr_data, 32'hCAFEA544);
    check("sb.mem", mem[4], 32'hCAFEA544);
    check("st.rdata_kept", bus.rdata, 32'h8899AABB);

    access("lh_mis", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, 1, 1'b1, 0);
    check("lh_mis.rdata", bus.rdata, 32'h8899AABB);
    access("rsvd", 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 1, 1'b1, 0);
    access("sw_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 1, 1'b1, 0);
    check("mis.mem", mem[4], 32'hCAFEA544);
    check("mis.rdata", bus.rdata, 32'h8899AABB);

    @(negedge clk);
    bus.req      = 1'b1;
    bus.we       = 1'b0;
    bus.size     = 2'b10;
    bus.sign_ext = 1'b0;
    bus.addr     = 32'h10;
    done_v       = '0;
    rdy_v        = '0;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 7; n++) begin
      done_v[n] = bus.done;
      rdy_v[n]  = bus.ready;
      if (n < 7) begin
        @(posedge clk);
        #1;
      end
    end
    bus.req = 1'b0;
    check("hold.done_cycles", 32'(done_v), 32'h88);
    check("hold.ready_cycles", 32'(rdy_v), 32'h10);
    check("hold.rdata", bus.rdata, 32'hCAFEA544);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("hold.idle", 32'(bus.ready), 32'd1);

    poke(6'd5, 32'h01020304);
    @(negedge clk);
    wr_snap      = wr_cnt;
    bus.req      = 1'b1;
    bus.we       = 1'b1;
    bus.size     = 2'b00;
    bus.addr     = 32'h14;
    bus.wdata    = 32'h000000FF;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    check("rmw.in_wait", 32'(bus.ram_address), 32'd5);
    rst_n = 1'b0;
    #1;
    check("arst.ready", 32'(bus.ready), 32'd1);
    check("arst.done", 32'(bus.done), 32'd0);
    check("arst.rdata", bus.rdata, 32'h0);
    check("arst.wren", 32'(bus.ram_wren), 32'd0);
    check("arst.address", 32'(bus.ram_address), 32'd0);
    check("arst.data", bus.ram_data, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst.no_write", 32'(wr_cnt - wr_snap), 32'd0);
    check("arst.mem", mem[5], 32'h01020304);
    access("post_rst", 1'b1, 2'b00, 1'b0, 32'h14, 32'h000000FF, 4, 1'b0, 1);
    check("post_rst.mem", mem[5], 32'h010203FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
